// File: rtl/keypad_pkg_amisha.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, idle patterns,
// row rotation sequence and small decode helpers.
package keypad_pkg_amisha;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam logic [3:0] ROW_IDLE = 4'b1111;
  localparam logic [3:0] COL_NONE = 4'b1111;

  localparam logic [3:0] ROW_0 = 4'b1110;
  localparam logic [3:0] ROW_1 = 4'b1101;
  localparam logic [3:0] ROW_2 = 4'b1011;
  localparam logic [3:0] ROW_3 = 4'b0111;

  function automatic logic [3:0] next_row(input logic [3:0] row);
    case (row)
      ROW_0:   next_row = ROW_1;
      ROW_1:   next_row = ROW_2;
      ROW_2:   next_row = ROW_3;
      default: next_row = ROW_0;
    endcase
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] row);
    case (row)
      ROW_1:   row_index = 2'd1;
      ROW_2:   row_index = 2'd2;
      ROW_3:   row_index = 2'd3;
      default: row_index = 2'd0;
    endcase
  endfunction

  // Lowest-index active-low column wins when several keys share the row.
  function automatic logic [1:0] lowest_low(input logic [3:0] col);
    if (!col[0])      lowest_low = 2'd0;
    else if (!col[1]) lowest_low = 2'd1;
    else if (!col[2]) lowest_low = 2'd2;
    else              lowest_low = 2'd3;
  endfunction

endpackage

// File: rtl/scan_tick_amisha.sv
// Enabled up-counter with terminal-count strobe; WRAP=1 gives a periodic tick
// (row prescaler, repeat timer), WRAP=0 saturates at N-1 (debounce timer).
module scan_tick_amisha #(
  parameter int unsigned N    = 4,
  parameter bit          WRAP = 1'b1,
  localparam int unsigned W   = (N > 1) ? $clog2(N) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    tc    = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) cnt_d = WRAP ? '0 : cnt_q;
      else               cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scan_amisha.sv
// 4x4 keypad scanner: active-low row drive, synchronized and debounced column returns,
// key code with one-cycle valid strobe. Define KEYPAD_REPEAT_EN for auto-repeat while held.
module keypad_scan_amisha
  import keypad_pkg_amisha::*;
#(
  parameter int unsigned SCAN_DIV  = 50_000,
  parameter int unsigned DB_CYCLES = 500_000
`ifdef KEYPAD_REPEAT_EN
  , parameter int unsigned REPEAT_CYCLES = 25_000_000
`endif
) (
  input  logic       clk_amisha,
  input  logic       reset_amisha,
  input  logic [3:0] col_amisha,
  output logic [3:0] row_amisha,
  output logic [3:0] key_code_amisha,
  output logic       key_valid_amisha,
  output logic       key_down_amisha
);

  logic [3:0] col_s1_q, col_s2_q;
  state_e     state_q, state_d;
  logic [3:0] row_q, row_d;
  logic [3:0] pat_q, pat_d;
  logic [3:0] pend_q, pend_d;
  logic [3:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       down_q, down_d;

  logic [3:0] col_s;
  logic       pre_tc, db_en, db_clr, db_tc, rep_tc;

  assign col_s = col_s2_q;

  scan_tick_amisha #(.N(SCAN_DIV), .WRAP(1'b1)) u_prescale (
    .clk (clk_amisha),
    .rst (reset_amisha),
    .en  (state_q == SCAN),
    .clr (state_q != SCAN),
    .tc  (pre_tc)
  );

  // One timer serves both press and release debounce; it idles cleared in SCAN/HOLD.
  assign db_en  = ((state_q == DEBOUNCE) && (col_s == pat_q)) ||
                  ((state_q == RELEASE)  && (col_s == COL_NONE));
  assign db_clr = (state_q == SCAN) || (state_q == HOLD);

  scan_tick_amisha #(.N(DB_CYCLES), .WRAP(1'b0)) u_debounce (
    .clk (clk_amisha),
    .rst (reset_amisha),
    .en  (db_en),
    .clr (db_clr),
    .tc  (db_tc)
  );

`ifdef KEYPAD_REPEAT_EN
  scan_tick_amisha #(.N(REPEAT_CYCLES), .WRAP(1'b1)) u_repeat (
    .clk (clk_amisha),
    .rst (reset_amisha),
    .en  (state_q == HOLD),
    .clr (state_q != HOLD),
    .tc  (rep_tc)
  );
`else
  assign rep_tc = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    pat_d   = pat_q;
    pend_d  = pend_q;
    code_d  = code_q;
    valid_d = 1'b0;
    down_d  = down_q;
    case (state_q)
      SCAN: begin
        if (pre_tc) begin
          if (col_s != COL_NONE) begin
            state_d = DEBOUNCE;
            pat_d   = col_s;
            pend_d  = {row_index(row_q), lowest_low(col_s)};
          end else begin
            row_d = next_row(row_q);
          end
        end
      end
      DEBOUNCE: begin
        if (col_s != pat_q) begin
          state_d = SCAN;
          row_d   = next_row(row_q);
        end else if (db_tc) begin
          state_d = HOLD;
          code_d  = pend_q;
          valid_d = 1'b1;
          down_d  = 1'b1;
        end
      end
      HOLD: begin
        if (col_s == COL_NONE) state_d = RELEASE;
        else if (rep_tc)       valid_d = 1'b1;
      end
      RELEASE: begin
        if (col_s != COL_NONE) begin
          state_d = HOLD;
        end else if (db_tc) begin
          state_d = SCAN;
          down_d  = 1'b0;
          row_d   = next_row(row_q);
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      col_s1_q <= COL_NONE;
      col_s2_q <= COL_NONE;
      state_q  <= SCAN;
      row_q    <= ROW_0;
      pat_q    <= COL_NONE;
      pend_q   <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      down_q   <= 1'b0;
    end else begin
      col_s1_q <= col_amisha;
      col_s2_q <= col_s1_q;
      state_q  <= state_d;
      row_q    <= row_d;
      pat_q    <= pat_d;
      pend_q   <= pend_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      down_q   <= down_d;
    end
  end

  assign row_amisha       = row_q;
  assign key_code_amisha  = code_q;
  assign key_valid_amisha = valid_q;
  assign key_down_amisha  = down_q;

endmodule

// File: tb/tb_keypad_scan_amisha.sv
// Directed bench for keypad_scan_amisha with a behavioural 4x4 key matrix model.
// Covers the auto-repeat path when KEYPAD_REPEAT_EN is defined.
module tb_keypad_scan_amisha;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;

  logic [15:0] key_mask  = 16'h0000;
  logic [3:0]  col_force = 4'h0;
  logic [3:0]  col_m;

  int checks   = 0;
  int errors   = 0;
  int n_strobe = 0;
  int base;
  logic prev_valid = 1'b0;
  bit   ok;

  always #5 clk = ~clk;

  keypad_scan_amisha #(
    .SCAN_DIV (4),
    .DB_CYCLES(8)
`ifdef KEYPAD_REPEAT_EN
    , .REPEAT_CYCLES(32)
`endif
  ) dut (
    .clk_amisha      (clk),
    .reset_amisha    (rst),
    .col_amisha      (col),
    .row_amisha      (row),
    .key_code_amisha (key_code),
    .key_valid_amisha(key_valid),
    .key_down_amisha (key_down)
  );

  // Pressed key (r,c) pulls column c low while row r is driven low.
  always_comb begin
    col_m = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && key_mask[r*4+c]) col_m[c] = 1'b0;
    col = col_m & ~col_force;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (key_valid) n_strobe++;
      check("valid_one_cycle", 32'(key_valid && prev_valid), 0);
    end
    prev_valid <= key_valid;
  end

  task automatic wait_strobe(input int max, output bit found);
    found = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (key_valid) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_up(input int max, output bit found);
    found = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!key_down) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic [3:0] rows [4];
    rows[0] = 4'b1110; rows[1] = 4'b1101; rows[2] = 4'b1011; rows[3] = 4'b0111;

    // Reset values and idle scanning
    repeat (3) @(negedge clk);
    check("rst_row",   32'(row), 'hE);
    check("rst_code",  32'(key_code), 0);
    check("rst_valid", 32'(key_valid), 0);
    check("rst_down",  32'(key_down), 0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i != 0) @(negedge clk);
      check($sformatf("idle_row_%0d", i), 32'(row), 32'(rows[i/4]));
    end
    #1 check("idle_no_strobe", 32'(n_strobe), 0);

    // Key 6: row 1, col 2
    base = n_strobe;
    key_mask = 16'h0040;
    wait_strobe(60, ok);
    check("k6_strobe_seen", 32'(ok), 1);
    check("k6_code", 32'(key_code), 6);
    check("k6_down", 32'(key_down), 1);
    check("k6_row_frozen", 32'(row), 'hD);
    repeat (20) @(negedge clk);
    #1 check("k6_single_strobe", 32'(n_strobe - base), 1);
    check("k6_row_held", 32'(row), 'hD);
    @(negedge clk);
    key_mask = 16'h0000;
    repeat (8) @(negedge clk);
    check("k6_down_during_rel", 32'(key_down), 1);
    wait_up(10, ok);
    check("k6_released", 32'(ok), 1);
    check("k6_resume_row2", 32'(row), 'hB);
    check("k6_code_held", 32'(key_code), 6);

    // 3-cycle glitch on col[0] just before a terminal count
    base = n_strobe;
    @(negedge clk);
    col_force = 4'b0001;
    repeat (3) @(negedge clk);
    check("glitch_row_frozen", 32'(row), 'hB);
    col_force = 4'b0000;
    repeat (2) @(negedge clk);
    check("glitch_still_db", 32'(row), 'hB);
    @(negedge clk);
    check("glitch_resume_row3", 32'(row), 'h7);
    check("glitch_code", 32'(key_code), 6);
    check("glitch_down", 32'(key_down), 0);
    #1 check("glitch_no_strobe", 32'(n_strobe - base), 0);

    // Keys 13 and 15 together on row 3
    base = n_strobe;
    key_mask = 16'hA000;
    wait_strobe(60, ok);
    check("k13_strobe_seen", 32'(ok), 1);
    check("k13_code", 32'(key_code), 13);
    check("k13_row", 32'(row), 'h7);
    key_mask = 16'h0000;
    wait_up(20, ok);
    check("k13_released", 32'(ok), 1);
    check("k13_resume_row0", 32'(row), 'hE);
    #1 check("k13_single_strobe", 32'(n_strobe - base), 1);

    // Key 9 with bouncing release: high 3, low 2, then high
    base = n_strobe;
    key_mask = 16'h0200;
    wait_strobe(60, ok);
    check("k9_strobe_seen", 32'(ok), 1);
    check("k9_code", 32'(key_code), 9);
    key_mask = 16'h0000;
    repeat (3) @(negedge clk);
    key_mask = 16'h0200;
    repeat (2) @(negedge clk);
    check("bounce_down_mid", 32'(key_down), 1);
    key_mask = 16'h0000;
    repeat (10) @(negedge clk);
    check("bounce_down_late", 32'(key_down), 1);
    @(negedge clk);
    check("bounce_down_clear", 32'(key_down), 0);
    check("bounce_resume_row3", 32'(row), 'h7);
    #1 check("bounce_single_strobe", 32'(n_strobe - base), 1);

    // Key 5 held for 100 cycles after acceptance
    base = n_strobe;
    key_mask = 16'h0020;
    wait_strobe(60, ok);
    check("k5_strobe_seen", 32'(ok), 1);
    check("k5_code", 32'(key_code), 5);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
`ifdef KEYPAD_REPEAT_EN
      check($sformatf("hold_valid_%0d", k), 32'(key_valid), 32'((k % 32) == 0));
`else
      check($sformatf("hold_valid_%0d", k), 32'(key_valid), 0);
`endif
      check($sformatf("hold_code_%0d", k), 32'(key_code), 5);
    end
    #1;
`ifdef KEYPAD_REPEAT_EN
    check("hold_strobe_count", 32'(n_strobe - base), 4);
`else
    check("hold_strobe_count", 32'(n_strobe - base), 1);
`endif

    // Reset mid-hold
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_row",   32'(row), 'hE);
    check("midrst_code",  32'(key_code), 0);
    check("midrst_valid", 32'(key_valid), 0);
    check("midrst_down",  32'(key_down), 0);
    key_mask = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("post_rst_row0", 32'(row), 'hE);
    repeat (3) @(negedge clk);
    check("post_rst_row0_end", 32'(row), 'hE);
    @(negedge clk);
    check("post_rst_row1", 32'(row), 'hD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
